eval_sequencer: RTL and testbench
=================================

EVAL_SEQUENCER -- requirements
Module: eval_sequencer

Interface
REQ-001 Parameter: ADDR_W, 4, sample-address width (up to 16 test samples).
REQ-002 Parameter: DATA_W, 32, activation and error-counter width.
REQ-003 clk  input  1  single clock; all flops rising-edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 start  input  1  one-cycle pulse; begins a test-set pass when IDLE.
REQ-006 num_samples  input  ADDR_W  last sample address of the pass (inclusive); sampled on accepted start.
REQ-007 mem_rd_en  output  1  read strobe to the test-data/label memory.
REQ-008 addr_counter  output  ADDR_W  current sample address.
REQ-009 test_data  input  4  class label, valid exactly 1 cycle after mem_rd_en.
REQ-010 neuron_start  output  1  one-cycle pulse launching the 4-neuron evaluate datapath.
REQ-011 neuron_done  input  1  one-cycle pulse; activate_n0..n3 valid in that cycle.
REQ-012 activate_n0..activate_n3  input  DATA_W each  signed neuron activations.
REQ-013 predicted  output  2  argmax index of the last evaluated sample.
REQ-014 error_counter  output  DATA_W  misclassifications in the current/last pass.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse when a pass completes.

Function
REQ-017 States SHALL be IDLE, FETCH, LATCH, LAUNCH, WAIT, COMPARE, NEXT, FINISH.
- IDLE: start=1 -> FETCH; clear error_counter and addr_counter to 0, capture num_samples.
- FETCH: mem_rd_en=1 for one cycle -> LATCH.
- LATCH: register test_data into label register -> LAUNCH.
- LAUNCH: neuron_start=1 for one cycle -> WAIT.
- WAIT: hold until neuron_done=1 -> COMPARE, registering all four activations.
- COMPARE: compute argmax, update predicted; if predicted != label[1:0] or label > 3, increment error_counter -> NEXT.
- NEXT: addr_counter == captured num_samples -> FINISH; else addr_counter+1 -> FETCH.
- FINISH: done=1 for one cycle -> IDLE.
REQ-018 Argmax SHALL use signed DATA_W compare; ties resolve to the lowest index.
REQ-019 error_counter SHALL saturate at all-ones and never wrap.
REQ-020 start SHALL be ignored while busy=1.
REQ-021 neuron_done outside WAIT SHALL be ignored.
REQ-022 num_samples=0 SHALL evaluate exactly one sample (address 0).
REQ-023 addr_counter SHALL NOT wrap within a pass; num_samples=15 evaluates addresses 0..15 then finishes.
REQ-024 Per-sample latency with immediate neuron_done SHALL be 6 cycles (FETCH..NEXT); done asserts 1 cycle after the final NEXT.
REQ-025 error_counter and predicted SHALL hold their final values in IDLE until the next accepted start.

Reset
REQ-026 On reset=0, state=IDLE; addr_counter=0, error_counter=0, predicted=0, mem_rd_en=0, neuron_start=0, busy=0, done=0, label and activation registers=0.
REQ-027 Reset mid-pass SHALL abort immediately; no done pulse is produced.

Configuration
REQ-028 Macro EVAL_TIMEOUT_EN: when defined, an 8-bit watchdog counts WAIT cycles; at 255 without neuron_done the sample counts as an error, a sticky output timeout_flag (1 bit, cleared on accepted start and reset) sets, and the FSM proceeds to NEXT.
REQ-029 Without EVAL_TIMEOUT_EN, WAIT SHALL hold indefinitely and the timeout_flag port SHALL not exist.

Structure
REQ-030 Package eval_pkg SHALL hold the state enum, ADDR_W/DATA_W defaults, and the 255-cycle timeout constant.
REQ-031 Argmax SHALL be a combinational sub-module argmax4 (four signed inputs, 2-bit index out).

Verification
REQ-032 num_samples=3, labels 0,1,2,3, activations peaking at the matching neuron -> error_counter=0, one done pulse, addr_counter ends at 3.
REQ-033 num_samples=1, label 2, activations (5,9,9,-1) -> predicted=1 (tie low), error_counter=2 after both samples mismatch.
REQ-034 Activations (-10,-3,-7,-20), label 1 -> predicted=1, no error (signed compare).
REQ-035 start pulsed again mid-pass -> ignored; reset=0 mid-WAIT -> all outputs reset values, no done.
REQ-036 EVAL_TIMEOUT_EN defined, neuron_done withheld for 300 cycles -> timeout_flag=1 at cycle 255 in WAIT, error_counter+1, pass continues.

Source files
------------

// File: rtl/eval_pkg.sv
// Shared types and constants for the eval_sequencer test-set evaluation block.
// Holds the sequencer state encoding, default widths and the WAIT watchdog limit.
package eval_pkg;

    localparam int ADDR_W_DEF     = 4;
    localparam int DATA_W_DEF     = 32;
    localparam int TIMEOUT_CYCLES = 255;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        LAUNCH,
        WAIT,
        COMPARE,
        NEXT,
        FINISH
    } state_t;

    // A label outside 0..3 can never match a 2-bit prediction, so it always counts as an error.
    function automatic logic is_misclassified(input logic [1:0] pred, input logic [3:0] label);
        return (pred != label[1:0]) || (label > 4'd3);
    endfunction

endpackage

// File: rtl/eval_sequencer_if.sv
// Memory and neuron-datapath handshake bundle driven by eval_sequencer.
// The master side is the sequencer; the slave side is the memory plus 4-neuron datapath.
interface eval_sequencer_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);

    logic                     mem_rd_en;
    logic [ADDR_W-1:0]        addr_counter;
    logic [3:0]               test_data;
    logic                     neuron_start;
    logic                     neuron_done;
    logic signed [DATA_W-1:0] activate_n0;
    logic signed [DATA_W-1:0] activate_n1;
    logic signed [DATA_W-1:0] activate_n2;
    logic signed [DATA_W-1:0] activate_n3;

    modport master (
        output mem_rd_en,
        output addr_counter,
        output neuron_start,
        input  test_data,
        input  neuron_done,
        input  activate_n0,
        input  activate_n1,
        input  activate_n2,
        input  activate_n3
    );

    modport slave (
        input  mem_rd_en,
        input  addr_counter,
        input  neuron_start,
        output test_data,
        output neuron_done,
        output activate_n0,
        output activate_n1,
        output activate_n2,
        output activate_n3
    );

endinterface

// File: rtl/argmax4.sv
// Combinational argmax over four signed activations.
// Only a strictly greater value replaces the running best, so ties resolve to the lowest index.
module argmax4 #(
    parameter int DATA_W = 32
) (
    input  logic signed [DATA_W-1:0] a0,
    input  logic signed [DATA_W-1:0] a1,
    input  logic signed [DATA_W-1:0] a2,
    input  logic signed [DATA_W-1:0] a3,
    output logic        [1:0]        idx
);

    logic signed [DATA_W-1:0] best;

    always_comb begin
        best = a0;
        idx  = 2'd0;
        if (a1 > best) begin
            best = a1;
            idx  = 2'd1;
        end
        if (a2 > best) begin
            best = a2;
            idx  = 2'd2;
        end
        if (a3 > best) begin
            best = a3;
            idx  = 2'd3;
        end
    end

endmodule

// File: rtl/eval_sequencer.sv
// Walks a test set: fetch label, launch the 4-neuron datapath, argmax, count misclassifications.
// Optional WAIT watchdog and timeout_flag port are enabled by defining EVAL_TIMEOUT_EN.
module eval_sequencer
    import eval_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] num_samples,
    eval_sequencer_if.master  bus,
    output logic [1:0]        predicted,
    output logic [DATA_W-1:0] error_counter,
    output logic              busy,
    output logic              done
`ifdef EVAL_TIMEOUT_EN
    ,
    output logic              timeout_flag
`endif
);

    state_t                   state;
    logic [ADDR_W-1:0]        last_addr;
    logic [3:0]               label;
    logic signed [DATA_W-1:0] act0;
    logic signed [DATA_W-1:0] act1;
    logic signed [DATA_W-1:0] act2;
    logic signed [DATA_W-1:0] act3;
    logic [1:0]               max_idx;
    logic [DATA_W-1:0]        error_inc;

`ifdef EVAL_TIMEOUT_EN
    logic [7:0]               wd_cnt;
`endif

    argmax4 #(
        .DATA_W (DATA_W)
    ) u_argmax (
        .a0  (act0),
        .a1  (act1),
        .a2  (act2),
        .a3  (act3),
        .idx (max_idx)
    );

    // Error count sticks at all-ones instead of wrapping back to zero.
    assign error_inc = (&error_counter) ? error_counter : error_counter + DATA_W'(1);

    // Outputs are set on the transition into the state that owns them, so each strobe is a clean flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            last_addr        <= '0;
            label            <= '0;
            act0             <= '0;
            act1             <= '0;
            act2             <= '0;
            act3             <= '0;
            predicted        <= '0;
            error_counter    <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            bus.mem_rd_en    <= 1'b0;
            bus.addr_counter <= '0;
            bus.neuron_start <= 1'b0;
`ifdef EVAL_TIMEOUT_EN
            wd_cnt           <= '0;
            timeout_flag     <= 1'b0;
`endif
        end else begin
            bus.mem_rd_en    <= 1'b0;
            bus.neuron_start <= 1'b0;
            done             <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state            <= FETCH;
                        busy             <= 1'b1;
                        bus.mem_rd_en    <= 1'b1;
                        bus.addr_counter <= '0;
                        error_counter    <= '0;
                        last_addr        <= num_samples;
`ifdef EVAL_TIMEOUT_EN
                        timeout_flag     <= 1'b0;
`endif
                    end
                end

                FETCH: begin
                    state <= LATCH;
                end

                LATCH: begin
                    label            <= bus.test_data;
                    bus.neuron_start <= 1'b1;
                    state            <= LAUNCH;
                end

                LAUNCH: begin
                    state  <= WAIT;
`ifdef EVAL_TIMEOUT_EN
                    wd_cnt <= '0;
`endif
                end

                WAIT: begin
                    if (bus.neuron_done) begin
                        act0  <= bus.activate_n0;
                        act1  <= bus.activate_n1;
                        act2  <= bus.activate_n2;
                        act3  <= bus.activate_n3;
                        state <= COMPARE;
                    end
`ifdef EVAL_TIMEOUT_EN
                    // A stalled datapath costs the sample, not the pass.
                    else if (wd_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                        error_counter <= error_inc;
                        timeout_flag  <= 1'b1;
                        state         <= NEXT;
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end
`endif
                end

                COMPARE: begin
                    predicted <= max_idx;
                    if (is_misclassified(max_idx, label)) begin
                        error_counter <= error_inc;
                    end
                    state <= NEXT;
                end

                NEXT: begin
                    if (bus.addr_counter == last_addr) begin
                        done  <= 1'b1;
                        state <= FINISH;
                    end else begin
                        bus.addr_counter <= bus.addr_counter + ADDR_W'(1);
                        bus.mem_rd_en    <= 1'b1;
                        state            <= FETCH;
                    end
                end

                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eval_sequencer.sv
// Directed bench for eval_sequencer with behavioural label memory and neuron datapath models.
// Define EVAL_TIMEOUT_EN to also exercise the WAIT watchdog.
module tb_eval_sequencer;
    import eval_pkg::*;

    localparam int AW = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] num_samples = '0;
    logic [1:0]    predicted;
    logic [DW-1:0] error_counter;
    logic          busy;
    logic          done;
`ifdef EVAL_TIMEOUT_EN
    logic          timeout_flag;
`endif

    int checks = 0;
    int failures = 0;
    int done_total = 0;

    logic [3:0]               mem_label [16];
    logic signed [DW-1:0]     mem_act   [16][4];
    int                       nd_delay  [16];

    typedef struct {
        logic [3:0]           label;
        logic signed [DW-1:0] a0;
        logic signed [DW-1:0] a1;
        logic signed [DW-1:0] a2;
        logic signed [DW-1:0] a3;
        logic [1:0]           exp_pred;
        logic [DW-1:0]        exp_err;
    } vec_t;

    vec_t vecs [9];

    eval_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    eval_sequencer #(
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .num_samples   (num_samples),
        .bus           (bus),
        .predicted     (predicted),
        .error_counter (error_counter),
        .busy          (busy),
        .done          (done)
`ifdef EVAL_TIMEOUT_EN
        ,
        .timeout_flag  (timeout_flag)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_total++;

    // Label memory: data appears one cycle after the read strobe, garbage (label 14) otherwise.
    initial begin : mem_model
        logic [3:0] a;
        bus.test_data = 4'hE;
        forever begin
            @(negedge clk);
            if (bus.mem_rd_en === 1'b1) begin
                a = bus.addr_counter;
                @(posedge clk);
                #1 bus.test_data = mem_label[a];
                @(posedge clk);
                #1 bus.test_data = 4'hE;
            end
        end
    end

    // Neuron datapath: pulses neuron_done nd_delay cycles after launch; a delay of 1000+ never answers.
    initial begin : neuron_model
        logic [3:0] a;
        bus.neuron_done = 1'b0;
        bus.activate_n0 = '0;
        bus.activate_n1 = '0;
        bus.activate_n2 = '0;
        bus.activate_n3 = 32'sd1000;
        forever begin
            @(negedge clk);
            if (bus.neuron_start === 1'b1) begin
                a = bus.addr_counter;
                if (nd_delay[a] < 1000) begin
                    @(posedge clk);
                    repeat (nd_delay[a]) @(posedge clk);
                    #1;
                    bus.activate_n0 = mem_act[a][0];
                    bus.activate_n1 = mem_act[a][1];
                    bus.activate_n2 = mem_act[a][2];
                    bus.activate_n3 = mem_act[a][3];
                    bus.neuron_done = 1'b1;
                    @(posedge clk);
                    #1;
                    bus.neuron_done = 1'b0;
                    bus.activate_n0 = '0;
                    bus.activate_n1 = '0;
                    bus.activate_n2 = '0;
                    bus.activate_n3 = 32'sd1000;
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic set_vec(input int i, input logic [3:0] label,
                           input logic signed [DW-1:0] a0, input logic signed [DW-1:0] a1,
                           input logic signed [DW-1:0] a2, input logic signed [DW-1:0] a3,
                           input logic [1:0] exp_pred, input logic [DW-1:0] exp_err);
        vecs[i].label    = label;
        vecs[i].a0       = a0;
        vecs[i].a1       = a1;
        vecs[i].a2       = a2;
        vecs[i].a3       = a3;
        vecs[i].exp_pred = exp_pred;
        vecs[i].exp_err  = exp_err;
    endtask

    task automatic set_sample(input int addr, input logic [3:0] label,
                              input logic signed [DW-1:0] a0, input logic signed [DW-1:0] a1,
                              input logic signed [DW-1:0] a2, input logic signed [DW-1:0] a3);
        mem_label[addr]  = label;
        mem_act[addr][0] = a0;
        mem_act[addr][1] = a1;
        mem_act[addr][2] = a2;
        mem_act[addr][3] = a3;
    endtask

    // Pulses start and counts negedges from the accepting edge until done is seen.
    task automatic apply_stimulus(input logic [AW-1:0] n, output int lat);
        logic got;
        @(posedge clk);
        #1;
        num_samples = n;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        num_samples = 4'hA;
        lat = 0;
        got = 1'b0;
        while (lat < 2000 && !got) begin
            @(negedge clk);
            lat++;
            got = (done === 1'b1);
        end
        check_output("done_within_budget", 64'(got), 64'd1);
        @(negedge clk);
    endtask

    initial begin : main
        int lat;
        int d0;
        logic got;

        for (int i = 0; i < 16; i++) begin
            nd_delay[i] = 0;
            set_sample(i, 4'd0, 0, 0, 0, 0);
        end

        set_vec(0, 4'd0, 32'sd10, 32'sd1, 32'sd2, 32'sd3, 2'd0, 0);
        set_vec(1, 4'd1, -32'sd10, -32'sd3, -32'sd7, -32'sd20, 2'd1, 0);
        set_vec(2, 4'd2, 32'sd5, 32'sd9, 32'sd9, -32'sd1, 2'd1, 1);
        set_vec(3, 4'd3, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 2'd0, 1);
        set_vec(4, 4'd4, 32'sd7, 32'sd1, 32'sd1, 32'sd1, 2'd0, 1);
        set_vec(5, 4'd3, 32'sd1, 32'sd2, 32'sd3, 32'sh7FFF_FFFF, 2'd3, 0);
        set_vec(6, 4'd2, -32'sd1, 32'sh8000_0000, 32'sd5, 32'sd5, 2'd2, 0);
        set_vec(7, 4'd0, 32'sh8000_0000, 32'sh8000_0000, 32'sh8000_0000, 32'sh8000_0000, 2'd0, 0);
        set_vec(8, 4'd1, -32'sd5, 32'sd3, -32'sd1, 32'sd2, 2'd1, 0);

        // Reset values
        repeat (3) @(negedge clk);
        check_output("rst_busy", 64'(busy), 64'd0);
        check_output("rst_done", 64'(done), 64'd0);
        check_output("rst_addr", 64'(bus.addr_counter), 64'd0);
        check_output("rst_err", 64'(error_counter), 64'd0);
        check_output("rst_pred", 64'(predicted), 64'd0);
        check_output("rst_rd_en", 64'(bus.mem_rd_en), 64'd0);
        check_output("rst_nstart", 64'(bus.neuron_start), 64'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Single-sample passes from the vector table
        for (int i = 0; i < 9; i++) begin
            set_sample(0, vecs[i].label, vecs[i].a0, vecs[i].a1, vecs[i].a2, vecs[i].a3);
            apply_stimulus(4'd0, lat);
            check_output($sformatf("vec%0d_pred", i), 64'(predicted), 64'(vecs[i].exp_pred));
            check_output($sformatf("vec%0d_err", i), 64'(error_counter), 64'(vecs[i].exp_err));
            check_output($sformatf("vec%0d_lat", i), 64'(lat), 64'd7);
            check_output($sformatf("vec%0d_addr", i), 64'(bus.addr_counter), 64'd0);
        end

        // Four samples, all correct
        for (int i = 0; i < 4; i++)
            set_sample(i, 4'(i), (i == 0) ? 100 : 0, (i == 1) ? 100 : 1, (i == 2) ? 100 : 2, (i == 3) ? 100 : 3);
        d0 = done_total;
        apply_stimulus(4'd3, lat);
        check_output("four_err", 64'(error_counter), 64'd0);
        check_output("four_addr", 64'(bus.addr_counter), 64'd3);
        check_output("four_pred", 64'(predicted), 64'd3);
        check_output("four_lat", 64'(lat), 64'd25);
        check_output("four_done_pulses", 64'(done_total - d0), 64'd1);
        check_output("four_busy_after", 64'(busy), 64'd0);

        // Two mismatching samples with a tie, then hold in IDLE
        set_sample(0, 4'd2, 32'sd5, 32'sd9, 32'sd9, -32'sd1);
        set_sample(1, 4'd2, 32'sd5, 32'sd9, 32'sd9, -32'sd1);
        apply_stimulus(4'd1, lat);
        check_output("tie_pred", 64'(predicted), 64'd1);
        check_output("tie_err", 64'(error_counter), 64'd2);
        check_output("tie_addr", 64'(bus.addr_counter), 64'd1);
        repeat (5) @(negedge clk);
        check_output("hold_err", 64'(error_counter), 64'd2);
        check_output("hold_pred", 64'(predicted), 64'd1);
        check_output("hold_busy", 64'(busy), 64'd0);

        // Second start while busy must not restart or shorten the pass
        d0 = done_total;
        @(posedge clk);
        #1;
        num_samples = 4'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        got = 1'b0;
        while (lat < 200 && !got) begin
            @(negedge clk);
            lat++;
            if (lat == 8) begin
                start = 1'b1;
                num_samples = 4'd0;
            end
            if (lat == 9) start = 1'b0;
            got = (done === 1'b1);
        end
        check_output("restart_done_seen", 64'(got), 64'd1);
        check_output("restart_lat", 64'(lat), 64'd13);
        check_output("restart_addr", 64'(bus.addr_counter), 64'd1);
        check_output("restart_err", 64'(error_counter), 64'd2);
        repeat (3) @(negedge clk);
        check_output("restart_done_pulses", 64'(done_total - d0), 64'd1);

        // Reset while the second sample sits in WAIT
        set_sample(0, 4'd3, 32'sd0, 32'sd9, 32'sd0, 32'sd0);
        set_sample(1, 4'd0, 32'sd9, 32'sd0, 32'sd0, 32'sd0);
        nd_delay[1] = 40;
        d0 = done_total;
        @(posedge clk);
        #1;
        num_samples = 4'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (11) @(negedge clk);
        check_output("pre_rst_busy", 64'(busy), 64'd1);
        check_output("pre_rst_err", 64'(error_counter), 64'd1);
        check_output("pre_rst_pred", 64'(predicted), 64'd1);
        check_output("pre_rst_addr", 64'(bus.addr_counter), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_output("mid_rst_busy", 64'(busy), 64'd0);
        check_output("mid_rst_err", 64'(error_counter), 64'd0);
        check_output("mid_rst_pred", 64'(predicted), 64'd0);
        check_output("mid_rst_addr", 64'(bus.addr_counter), 64'd0);
        check_output("mid_rst_rd_en", 64'(bus.mem_rd_en), 64'd0);
        check_output("mid_rst_nstart", 64'(bus.neuron_start), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (60) @(negedge clk);
        check_output("post_rst_no_done", 64'(done_total - d0), 64'd0);
        check_output("post_rst_busy", 64'(busy), 64'd0);
        check_output("post_rst_err", 64'(error_counter), 64'd0);
        nd_delay[1] = 0;

        // Full sixteen-sample pass; the last label is out of range
        for (int i = 0; i < 16; i++)
            set_sample(i, 4'(i % 4), (i % 4 == 0) ? 50 : 0, (i % 4 == 1) ? 50 : -1,
                       (i % 4 == 2) ? 50 : -2, (i % 4 == 3) ? 50 : -3);
        mem_label[15] = 4'd7;
        apply_stimulus(4'd15, lat);
        check_output("full_addr", 64'(bus.addr_counter), 64'd15);
        check_output("full_err", 64'(error_counter), 64'd1);
        check_output("full_pred", 64'(predicted), 64'd3);
        check_output("full_lat", 64'(lat), 64'd97);

`ifdef EVAL_TIMEOUT_EN
        // Datapath never answers for sample 0; watchdog fires and the pass carries on
        set_sample(0, 4'd0, 32'sd50, 32'sd0, 32'sd0, 32'sd0);
        set_sample(1, 4'd1, 32'sd0, 32'sd50, 32'sd0, 32'sd0);
        nd_delay[0] = 1000;
        apply_stimulus(4'd1, lat);
        check_output("tmo_flag", 64'(timeout_flag), 64'd1);
        check_output("tmo_err", 64'(error_counter), 64'd1);
        check_output("tmo_pred", 64'(predicted), 64'd1);
        check_output("tmo_addr", 64'(bus.addr_counter), 64'd1);
        check_output("tmo_lat", 64'(lat), 64'd266);
        nd_delay[0] = 0;
        apply_stimulus(4'd0, lat);
        check_output("tmo_flag_cleared", 64'(timeout_flag), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : global_guard
        #200000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

endmodule
